// File: rtl/sc_spi_dfc.sv
// SPI data FIFO controller: TX/RX word FIFOs and a one-frame-per-command sequencer for sc_spi_spc.
// TXDATA/RXRDATA read storage combinationally; SPISTART waits for fw TX words and fw free RX slots.
module sc_spi_dfc #(
  parameter int TXAW = 3,
  parameter int RXAW = 3
) (
  input  logic          SPICLK,
  input  logic          SYSRST,
  input  logic [8:0]    DWIDTH,
  input  logic          CMDSTART,
  output logic          CMDDONE,
  input  logic          FLUSH,
  input  logic          TXWE,
  input  logic [31:0]   TXWDATA,
  output logic          TXFULL,
  output logic [TXAW:0] TXLEVEL,
  output logic          TXOVF,
  input  logic          RXRE,
  output logic [31:0]   RXRDATA,
  output logic          RXEMPTY,
  output logic [RXAW:0] RXLEVEL,
  output logic          RXOVF,
  input  logic          OVFCLR,
  output logic          SPISTART,
  input  logic          SPIBUSY,
  output logic [31:0]   TXDATA,
  input  logic          TXDETECT,
  input  logic [31:0]   RXDATA,
  input  logic          RXVALID
);
  localparam int RXD = 1 << RXAW;
  localparam int TXD = 1 << TXAW;
  localparam logic [TXAW:0] TX_INC = {{TXAW{1'b0}}, 1'b1};
  localparam logic [RXAW:0] RX_INC = {{RXAW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_START, S_BUSY} state_t;
  state_t state, state_nxt;
  logic done_nxt;

  logic [4:0] fw, popcnt;
  logic txdet_q, rxval_q;
  logic tx_evt, rx_evt, in_frame, flush, wait_ok;

  logic [31:0]   tx_mem [TXD];
  logic [31:0]   rx_mem [RXD];
  logic [TXAW:0] tx_wp, tx_rp;
  logic [RXAW:0] rx_wp, rx_rp;
  logic tx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop;

  assign tx_evt   = TXDETECT ^ txdet_q;
  assign rx_evt   = RXVALID ^ rxval_q;
  assign in_frame = (state == S_START) || (state == S_BUSY);
  assign flush    = FLUSH && (state == S_IDLE);

  assign tx_empty = (tx_wp == tx_rp);
  assign TXFULL   = (tx_wp[TXAW] != tx_rp[TXAW]) && (tx_wp[TXAW-1:0] == tx_rp[TXAW-1:0]);
  assign TXLEVEL  = tx_wp - tx_rp;
  assign TXDATA   = tx_empty ? 32'd0 : tx_mem[tx_rp[TXAW-1:0]];

  assign RXEMPTY  = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RXAW] != rx_rp[RXAW]) && (rx_wp[RXAW-1:0] == rx_rp[RXAW-1:0]);
  assign RXLEVEL  = rx_wp - rx_rp;
  assign RXRDATA  = rx_mem[rx_rp[RXAW-1:0]];

  // Toggle events past the frame's word count (controller prefetch) never pop.
  assign tx_push = TXWE && !TXFULL;
  assign tx_pop  = tx_evt && in_frame && (popcnt < fw) && !tx_empty;
  assign rx_push = rx_evt && !rx_full;
  assign rx_pop  = RXRE && !RXEMPTY;

  assign wait_ok = (int'(TXLEVEL) >= int'(fw)) && ((RXD - int'(RXLEVEL)) >= int'(fw)) && !SPIBUSY;
  assign SPISTART = (state == S_START);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE:  if (CMDSTART) state_nxt = S_WAIT;
      S_WAIT:  if (wait_ok) state_nxt = S_START;
      S_START: if (SPIBUSY) state_nxt = S_BUSY;
      S_BUSY:  if (!SPIBUSY) begin
                 state_nxt = S_IDLE;
                 done_nxt  = 1'b1;
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge SPICLK or posedge SYSRST) begin
    if (SYSRST) begin
      state   <= S_IDLE;
      CMDDONE <= 1'b0;
      fw      <= 5'd1;
      popcnt  <= 5'd0;
      txdet_q <= 1'b0;
      rxval_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      CMDDONE <= done_nxt;
      txdet_q <= TXDETECT;
      rxval_q <= RXVALID;
      if (state == S_IDLE && CMDSTART) begin
        fw     <= {1'b0, DWIDTH[8:5]} + 5'd1;
        popcnt <= 5'd0;
      end else if (tx_evt && in_frame && (popcnt < fw)) begin
        popcnt <= popcnt + 5'd1;
      end
    end
  end

  // Overflow set takes priority over a same-cycle clear.
  always_ff @(posedge SPICLK or posedge SYSRST) begin
    if (SYSRST) begin
      TXOVF <= 1'b0;
      RXOVF <= 1'b0;
    end else begin
      TXOVF <= (TXOVF && !OVFCLR) || (TXWE && TXFULL);
      RXOVF <= (RXOVF && !OVFCLR) || (rx_evt && rx_full);
    end
  end

  always_ff @(posedge SPICLK or posedge SYSRST) begin
    if (SYSRST) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else if (flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_INC;
      if (tx_pop)  tx_rp <= tx_rp + TX_INC;
      if (rx_push) rx_wp <= rx_wp + RX_INC;
      if (rx_pop)  rx_rp <= rx_rp + RX_INC;
    end
  end

  always_ff @(posedge SPICLK) begin
    if (tx_push) tx_mem[tx_wp[TXAW-1:0]] <= TXWDATA;
    if (rx_push) rx_mem[rx_wp[RXAW-1:0]] <= RXDATA;
  end

endmodule

// File: tb/tb_sc_spi_dfc.sv
// Bench for sc_spi_dfc: acts as host and as SPI protocol controller, checked against a queue-based model.
module tb_sc_spi_dfc;
  localparam int DEPTH = 8;

  logic        SPICLK, SYSRST;
  logic [8:0]  DWIDTH;
  logic        CMDSTART, CMDDONE, FLUSH, TXWE, TXFULL, TXOVF;
  logic [31:0] TXWDATA, RXRDATA, TXDATA, RXDATA;
  logic [3:0]  TXLEVEL, RXLEVEL;
  logic        RXRE, RXEMPTY, RXOVF, OVFCLR, SPISTART, SPIBUSY, TXDETECT, RXVALID;

  sc_spi_dfc #(.TXAW(3), .RXAW(3)) dut (
    .SPICLK(SPICLK), .SYSRST(SYSRST), .DWIDTH(DWIDTH), .CMDSTART(CMDSTART), .CMDDONE(CMDDONE),
    .FLUSH(FLUSH), .TXWE(TXWE), .TXWDATA(TXWDATA), .TXFULL(TXFULL), .TXLEVEL(TXLEVEL),
    .TXOVF(TXOVF), .RXRE(RXRE), .RXRDATA(RXRDATA), .RXEMPTY(RXEMPTY), .RXLEVEL(RXLEVEL),
    .RXOVF(RXOVF), .OVFCLR(OVFCLR), .SPISTART(SPISTART), .SPIBUSY(SPIBUSY), .TXDATA(TXDATA),
    .TXDETECT(TXDETECT), .RXDATA(RXDATA), .RXVALID(RXVALID)
  );

  initial SPICLK = 1'b0;
  always #5 SPICLK = ~SPICLK;

  // Reference model: FIFO contents as queues, sticky flags as bits.
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit m_txovf, m_rxovf;
  bit exp_pop, flush_eff, rv_prev;
  int total = 0;
  int bad = 0;

  // One clock; applies to the model what the inputs held at the edge should do, then drops strobes.
  task automatic tick();
    bit tfull, rfull, rempty, rpush;
    tfull  = (txq.size() == DEPTH);
    rfull  = (rxq.size() == DEPTH);
    rempty = (rxq.size() == 0);
    rpush  = (RXVALID != rv_prev);
    rv_prev = RXVALID;
    @(posedge SPICLK);
    #1;
    if (SYSRST) begin
      txq.delete(); rxq.delete(); m_txovf = 0; m_rxovf = 0;
    end else begin
      if (OVFCLR) begin m_txovf = 0; m_rxovf = 0; end
      if (TXWE && tfull) m_txovf = 1;
      if (rpush && rfull) m_rxovf = 1;
      if (FLUSH && flush_eff) begin
        txq.delete(); rxq.delete();
      end else begin
        if (exp_pop && txq.size() > 0) void'(txq.pop_front());
        if (TXWE && !tfull) txq.push_back(TXWDATA);
        if (RXRE && !rempty) void'(rxq.pop_front());
        if (rpush && !rfull) rxq.push_back(RXDATA);
      end
    end
    TXWE = 0; RXRE = 0; OVFCLR = 0; FLUSH = 0; CMDSTART = 0; exp_pop = 0; flush_eff = 0;
  endtask

  task automatic write_tx(input logic [31:0] d);
    TXWE = 1; TXWDATA = d; tick();
  endtask

  task automatic push_rx(input logic [31:0] d);
    RXVALID = ~RXVALID; RXDATA = d; tick();
  endtask

  task automatic do_flush();
    FLUSH = 1; flush_eff = 1; tick();
  endtask

  // Plays the protocol controller for one frame of fw words; reports whether it started and finished.
  task automatic serve_frame(input int fw, output bit started, output bit done);
    int n;
    started = 0; done = 0; n = 0;
    while (SPISTART !== 1'b1 && n < 20) begin tick(); n++; end
    if (SPISTART !== 1'b1) return;
    started = 1;
    SPIBUSY = 1;
    for (int i = 0; i <= fw; i++) begin
      TXDETECT = ~TXDETECT; exp_pop = (i < fw);
      if (i < fw) begin RXVALID = ~RXVALID; RXDATA = $urandom; end
      tick();
    end
    SPIBUSY = 0;
    n = 0;
    do begin tick(); n++; end while (CMDDONE !== 1'b1 && n < 5);
    done = (CMDDONE === 1'b1);
  endtask

  task automatic test_reset();
    SYSRST = 1; tick(); tick();
    total++; if (TXLEVEL !== 4'd0) begin bad++; $display("FAIL rst_txlevel: got %0d want 0", TXLEVEL); end
    total++; if (TXFULL !== 1'b0) begin bad++; $display("FAIL rst_txfull: got %b want 0", TXFULL); end
    total++; if (RXEMPTY !== 1'b1) begin bad++; $display("FAIL rst_rxempty: got %b want 1", RXEMPTY); end
    total++; if (RXLEVEL !== 4'd0) begin bad++; $display("FAIL rst_rxlevel: got %0d want 0", RXLEVEL); end
    total++; if ({TXOVF, RXOVF} !== 2'b00) begin bad++; $display("FAIL rst_ovf: got %b%b want 00", TXOVF, RXOVF); end
    total++; if ({SPISTART, CMDDONE} !== 2'b00) begin bad++; $display("FAIL rst_ctl: got %b%b want 00", SPISTART, CMDDONE); end
    total++; if (TXDATA !== 32'd0) begin bad++; $display("FAIL rst_txdata: got %h want 0", TXDATA); end
    SYSRST = 0; tick();
  endtask

  task automatic test_single_frame();
    logic [31:0] w;
    int n;
    write_tx(32'hA5A5_0001);
    total++; if (TXDATA !== 32'hA5A5_0001) begin bad++; $display("FAIL sf_txdata: got %h want a5a50001", TXDATA); end
    DWIDTH = 9'd31; CMDSTART = 1; tick();
    n = 0;
    while (SPISTART !== 1'b1 && n < 5) begin tick(); n++; end
    total++; if (SPISTART !== 1'b1) begin bad++; $display("FAIL sf_spistart: got %b want 1", SPISTART); end
    SPIBUSY = 1; TXDETECT = ~TXDETECT; exp_pop = 1; tick();
    total++; if (TXLEVEL !== 4'd0) begin bad++; $display("FAIL sf_pop: got %0d want 0", TXLEVEL); end
    total++; if (SPISTART !== 1'b0) begin bad++; $display("FAIL sf_spistart_drop: got %b want 0", SPISTART); end
    TXDETECT = ~TXDETECT; tick();
    total++; if (TXLEVEL !== 4'd0) begin bad++; $display("FAIL sf_extra_toggle: got %0d want 0", TXLEVEL); end
    w = $urandom; write_tx(w);
    TXDETECT = ~TXDETECT; tick();
    total++; if (TXLEVEL !== 4'd1 || TXDATA !== w) begin
      bad++; $display("FAIL sf_no_pop_past_fw: got %0d/%h want 1/%h", TXLEVEL, TXDATA, w);
    end
    push_rx(32'h1234_5678);
    total++; if (RXLEVEL !== 4'd1 || RXRDATA !== 32'h1234_5678 || RXEMPTY !== 1'b0) begin
      bad++; $display("FAIL sf_rx: got %0d/%h/%b want 1/12345678/0", RXLEVEL, RXRDATA, RXEMPTY);
    end
    SPIBUSY = 0; tick();
    total++; if (CMDDONE !== 1'b1) begin bad++; $display("FAIL sf_cmddone: got %b want 1", CMDDONE); end
    tick();
    total++; if (CMDDONE !== 1'b0) begin bad++; $display("FAIL sf_cmddone_pulse: got %b want 0", CMDDONE); end
    RXRE = 1; tick();
    do_flush();
  endtask

  task automatic test_wait_gate();
    bit st, dn;
    write_tx($urandom); write_tx($urandom);
    DWIDTH = 9'd95; CMDSTART = 1; tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (SPISTART !== 1'b0) begin bad++; $display("FAIL wg_hold_%0d: got %b want 0", i, SPISTART); end
    end
    write_tx($urandom);
    total++; if (SPISTART !== 1'b0) begin bad++; $display("FAIL wg_early: got %b want 0", SPISTART); end
    tick();
    total++; if (SPISTART !== 1'b1) begin bad++; $display("FAIL wg_rise: got %b want 1", SPISTART); end
    serve_frame(3, st, dn);
    total++; if (!(st && dn)) begin bad++; $display("FAIL wg_frame: got start=%0d done=%0d want 1/1", st, dn); end
    total++; if (TXLEVEL !== 4'd0 || int'(RXLEVEL) !== 3) begin
      bad++; $display("FAIL wg_levels: got tx=%0d rx=%0d want 0/3", TXLEVEL, RXLEVEL);
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (RXRDATA !== rxq[0]) begin bad++; $display("FAIL wg_rxdata: got %h want %h", RXRDATA, rxq[0]); end
      RXRE = 1; tick();
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] first;
    bit st, dn;
    first = $urandom;
    write_tx(first);
    for (int i = 1; i < 9; i++) write_tx($urandom);
    total++; if (TXFULL !== 1'b1 || TXLEVEL !== 4'd8 || TXOVF !== 1'b1) begin
      bad++; $display("FAIL tf_full: got full=%b lvl=%0d ovf=%b want 1/8/1", TXFULL, TXLEVEL, TXOVF);
    end
    total++; if (TXDATA !== first) begin bad++; $display("FAIL tf_head: got %h want %h", TXDATA, first); end
    OVFCLR = 1; tick();
    total++; if (TXOVF !== 1'b0) begin bad++; $display("FAIL tf_ovfclr: got %b want 0", TXOVF); end
    // Write and pop in the same cycle while full: pop wins, write dropped, overflow flagged.
    DWIDTH = 9'd7; CMDSTART = 1; tick();
    st = 0;
    for (int i = 0; i < 5 && SPISTART !== 1'b1; i++) tick();
    total++; if (SPISTART !== 1'b1) begin bad++; $display("FAIL tf_start: got %b want 1", SPISTART); end
    SPIBUSY = 1; TXDETECT = ~TXDETECT; exp_pop = 1; TXWE = 1; TXWDATA = $urandom; tick();
    total++; if (TXLEVEL !== 4'd7 || TXOVF !== 1'b1 || TXDATA !== txq[0]) begin
      bad++; $display("FAIL tf_pop_write: got lvl=%0d ovf=%b head=%h want 7/1/%h", TXLEVEL, TXOVF, TXDATA, txq[0]);
    end
    SPIBUSY = 0; tick();
    total++; if (CMDDONE !== 1'b1) begin bad++; $display("FAIL tf_done: got %b want 1", CMDDONE); end
    OVFCLR = 1; do_flush();
    total++; if (TXLEVEL !== 4'd0 || TXOVF !== 1'b0) begin
      bad++; $display("FAIL tf_flush: got %0d/%b want 0/0", TXLEVEL, TXOVF);
    end
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < 8; i++) push_rx($urandom);
    total++; if (RXLEVEL !== 4'd8 || RXOVF !== 1'b0) begin
      bad++; $display("FAIL rf_fill: got %0d/%b want 8/0", RXLEVEL, RXOVF);
    end
    push_rx($urandom);
    total++; if (RXLEVEL !== 4'd8 || RXOVF !== 1'b1 || RXRDATA !== rxq[0]) begin
      bad++; $display("FAIL rf_drop: got %0d/%b/%h want 8/1/%h", RXLEVEL, RXOVF, RXRDATA, rxq[0]);
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (RXRDATA !== rxq[0]) begin bad++; $display("FAIL rf_read%0d: got %h want %h", i, RXRDATA, rxq[0]); end
      RXRE = 1; tick();
    end
    RXRE = 1; RXVALID = ~RXVALID; RXDATA = $urandom; tick();
    total++; if (RXLEVEL !== 4'd4 || RXRDATA !== rxq[0]) begin
      bad++; $display("FAIL rf_rd_push: got %0d/%h want 4/%h", RXLEVEL, RXRDATA, rxq[0]);
    end
    for (int i = 0; i < 4; i++) push_rx($urandom);
    OVFCLR = 1; RXVALID = ~RXVALID; RXDATA = $urandom; tick();
    total++; if (RXOVF !== 1'b1) begin bad++; $display("FAIL rf_set_wins: got %b want 1", RXOVF); end
    OVFCLR = 1; tick();
    total++; if (RXOVF !== 1'b0) begin bad++; $display("FAIL rf_clr: got %b want 0", RXOVF); end
    do_flush();
  endtask

  task automatic test_random_host();
    for (int c = 0; c < 120; c++) begin
      TXWE = ($urandom_range(0, 2) == 0); TXWDATA = $urandom;
      RXRE = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) begin RXVALID = ~RXVALID; RXDATA = $urandom; end
      if ($urandom_range(0, 3) == 0) TXDETECT = ~TXDETECT;
      OVFCLR = ($urandom_range(0, 9) == 0);
      tick();
      total++; if (int'(TXLEVEL) !== txq.size() || TXFULL !== (txq.size() == DEPTH)) begin
        bad++; $display("FAIL rh_tx c=%0d: got %0d/%b want %0d", c, TXLEVEL, TXFULL, txq.size());
      end
      total++; if (TXDATA !== ((txq.size() > 0) ? txq[0] : 32'd0)) begin
        bad++; $display("FAIL rh_txdata c=%0d: got %h", c, TXDATA);
      end
      total++; if (int'(RXLEVEL) !== rxq.size() || RXEMPTY !== (rxq.size() == 0)) begin
        bad++; $display("FAIL rh_rx c=%0d: got %0d/%b want %0d", c, RXLEVEL, RXEMPTY, rxq.size());
      end
      if (rxq.size() > 0) begin
        total++; if (RXRDATA !== rxq[0]) begin bad++; $display("FAIL rh_rxdata c=%0d: got %h want %h", c, RXRDATA, rxq[0]); end
      end
      total++; if (TXOVF !== m_txovf || RXOVF !== m_rxovf) begin
        bad++; $display("FAIL rh_ovf c=%0d: got %b%b want %b%b", c, TXOVF, RXOVF, m_txovf, m_rxovf);
      end
    end
    OVFCLR = 1; do_flush();
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 6; it++) begin
      int fw, add;
      bit st, dn;
      while (rxq.size() > 0) begin
        total++; if (RXRDATA !== rxq[0]) begin bad++; $display("FAIL bb_rxdata: got %h want %h", RXRDATA, rxq[0]); end
        RXRE = 1; tick();
      end
      fw = $urandom_range(1, 4);
      add = (txq.size() < fw) ? fw - txq.size() : 0;
      add += $urandom_range(0, DEPTH - txq.size() - add);
      for (int i = 0; i < add; i++) write_tx($urandom);
      DWIDTH = 9'((fw - 1) * 32 + $urandom_range(0, 31)); CMDSTART = 1; tick();
      serve_frame(fw, st, dn);
      total++; if (!(st && dn)) begin bad++; $display("FAIL bb_frame%0d: got start=%0d done=%0d want 1/1", it, st, dn); end
      total++; if (int'(TXLEVEL) !== txq.size() || int'(RXLEVEL) !== fw) begin
        bad++; $display("FAIL bb_levels%0d: got %0d/%0d want %0d/%0d", it, TXLEVEL, RXLEVEL, txq.size(), fw);
      end
      tick();
      total++; if (CMDDONE !== 1'b0) begin bad++; $display("FAIL bb_pulse%0d: got %b want 0", it, CMDDONE); end
    end
    while (rxq.size() > 0) begin RXRE = 1; tick(); end
    do_flush();
  endtask

  task automatic test_stuck_wait();
    for (int i = 0; i < 8; i++) write_tx($urandom);
    DWIDTH = 9'h1FF; CMDSTART = 1; tick();
    DWIDTH = 9'd31; CMDSTART = 1; tick();
    for (int i = 0; i < 8; i++) tick();
    total++; if (SPISTART !== 1'b0 || TXLEVEL !== 4'd8) begin
      bad++; $display("FAIL sw_stuck: got %b/%0d want 0/8", SPISTART, TXLEVEL);
    end
    FLUSH = 1; tick();
    total++; if (TXLEVEL !== 4'd8) begin bad++; $display("FAIL sw_flush_ignored: got %0d want 8", TXLEVEL); end
    SYSRST = 1; tick();
    SYSRST = 0; tick();
  endtask

  task automatic test_reset_busy();
    bit st, dn;
    int n;
    for (int i = 0; i < 5; i++) write_tx($urandom);
    push_rx($urandom);
    DWIDTH = 9'd31; CMDSTART = 1; tick();
    n = 0;
    while (SPISTART !== 1'b1 && n < 5) begin tick(); n++; end
    SPIBUSY = 1; tick();
    total++; if (TXLEVEL !== 4'd5 || SPISTART !== 1'b0) begin
      bad++; $display("FAIL rb_busy: got %0d/%b want 5/0", TXLEVEL, SPISTART);
    end
    SYSRST = 1; tick();
    total++; if (TXLEVEL !== 4'd0 || RXEMPTY !== 1'b1 || SPISTART !== 1'b0 || CMDDONE !== 1'b0) begin
      bad++; $display("FAIL rb_reset: got %0d/%b/%b/%b want 0/1/0/0", TXLEVEL, RXEMPTY, SPISTART, CMDDONE);
    end
    SPIBUSY = 0; TXDETECT = 0; RXVALID = 0; rv_prev = 0; SYSRST = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (CMDDONE !== 1'b0) begin bad++; $display("FAIL rb_no_done%0d: got %b want 0", i, CMDDONE); end
    end
    write_tx($urandom);
    DWIDTH = 9'd0; CMDSTART = 1; tick();
    serve_frame(1, st, dn);
    total++; if (!(st && dn) || TXLEVEL !== 4'd0) begin
      bad++; $display("FAIL rb_recover: got start=%0d done=%0d lvl=%0d want 1/1/0", st, dn, TXLEVEL);
    end
    RXRE = 1; tick();
  endtask

  task automatic test_flush();
    int n;
    write_tx($urandom); write_tx($urandom);
    DWIDTH = 9'd20; CMDSTART = 1; tick();
    n = 0;
    while (SPISTART !== 1'b1 && n < 5) begin tick(); n++; end
    SPIBUSY = 1; tick();
    FLUSH = 1; flush_eff = 0; tick();
    total++; if (TXLEVEL !== 4'd2) begin bad++; $display("FAIL fl_busy_ignored: got %0d want 2", TXLEVEL); end
    SPIBUSY = 0; tick(); tick();
    write_tx($urandom); push_rx($urandom); push_rx($urandom);
    total++; if (TXLEVEL !== 4'd3 || RXLEVEL !== 4'd2) begin
      bad++; $display("FAIL fl_setup: got %0d/%0d want 3/2", TXLEVEL, RXLEVEL);
    end
    do_flush();
    total++; if (TXLEVEL !== 4'd0 || RXLEVEL !== 4'd0 || RXEMPTY !== 1'b1 || TXDATA !== 32'd0) begin
      bad++; $display("FAIL fl_idle: got %0d/%0d/%b/%h want 0/0/1/0", TXLEVEL, RXLEVEL, RXEMPTY, TXDATA);
    end
  endtask

  initial begin
    SYSRST = 1; DWIDTH = 9'd31; CMDSTART = 0; FLUSH = 0; TXWE = 0; TXWDATA = 0; RXRE = 0;
    OVFCLR = 0; SPIBUSY = 0; TXDETECT = 0; RXDATA = 0; RXVALID = 0;
    exp_pop = 0; flush_eff = 0; rv_prev = 0; m_txovf = 0; m_rxovf = 0;
    test_reset();
    test_single_frame();
    test_wait_gate();
    test_tx_full();
    test_rx_full();
    test_random_host();
    test_back_to_back();
    test_stuck_wait();
    test_reset_busy();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_spi_dfc.md
Name: sc_spi_dfc

Overview:
SPI data FIFO controller, directly upstream/downstream of the SPI protocol controller (sc_spi_spc) inside the SPI engine. Buffers host TX words in a TX FIFO and presents the head word on TXDATA. Pops a word on each TXDETECT toggle and pushes RXDATA into an RX FIFO on each RXVALID toggle. Sequences one SPI frame per host command, asserting SPISTART only when enough TX data and RX space exist.

Parameters:
TXAW, 3, TX FIFO address width (depth 2**TXAW words)
RXAW, 3, RX FIFO address width (depth 2**RXAW words)

Ports:
SPICLK  in  1  engine clock, all logic posedge
SYSRST  in  1  asynchronous active-high reset
DWIDTH  in  9  frame width minus 1, in bits; same value the protocol controller uses
CMDSTART  in  1  one-cycle request to run one frame
CMDDONE  out  1  one-cycle pulse when the frame completes
FLUSH  in  1  clears both FIFOs; honoured only in IDLE
TXWE  in  1  host TX write strobe
TXWDATA  in  32  host TX word
TXFULL  out  1  TX FIFO full
TXLEVEL  out  TXAW+1  TX entries
TXOVF  out  1  sticky: write attempted while full
RXRE  in  1  host RX read strobe
RXRDATA  out  32  RX head word, valid when !RXEMPTY
RXEMPTY  out  1  RX FIFO empty
RXLEVEL  out  RXAW+1  RX entries
RXOVF  out  1  sticky: push attempted while full
OVFCLR  in  1  clears TXOVF and RXOVF
SPISTART  out  1  to controller
SPIBUSY  in  1  from controller
TXDATA  out  32  TX FIFO head, combinational from storage; 0 when empty
TXDETECT  in  1  toggle: controller latched TXDATA
RXDATA  in  32  controller RX word
RXVALID  in  1  toggle: RXDATA updated

Behaviour:
- Reset values: all FIFO pointers and levels 0, TXFULL=0, RXEMPTY=1, TXOVF=RXOVF=0, SPISTART=0, CMDDONE=0, state IDLE, toggle history registers 0.
- Toggle detection: registers txdet_q and rxval_q. Event = input XOR register; each event lasts one cycle.
- Frame words: fw = DWIDTH[8:5] + 1, range 1..16. fw is latched when CMDSTART is accepted.
- States:
  - IDLE: CMDSTART latches fw, clears popcnt, and moves to WAIT. CMDSTART outside IDLE is ignored.
  - WAIT: when TXLEVEL >= fw, free RX entries >= fw, and !SPIBUSY, assert SPISTART and move to START.
  - START: SPISTART held high until SPIBUSY=1 is sampled, then SPISTART=0 and move to BUSY.
  - BUSY: on SPIBUSY=0, pulse CMDDONE for one cycle and return to IDLE.
- If fw can never be satisfied (fw > FIFO depth), the block stays in WAIT. Only reset recovers it.
- TX pop: on a TXDETECT event in START or BUSY, pop only if popcnt < fw, then popcnt++. Events beyond fw are ignored; the controller's trailing prefetch toggle falls into this case. Events in IDLE/WAIT update txdet_q only.
- RX push: on an RXVALID event, push RXDATA if not full. If full, drop the word and set RXOVF. Pushes are accepted in any state.
- Host TX write: when full, the write is ignored and TXOVF is set. Simultaneous write and pop while full: the pop occurs, the write is dropped, and TXOVF is set.
- Host RX read: when empty, the read is ignored and RXRDATA holds. Simultaneous push and read: the level is unchanged and both pointers advance.
- Simultaneous OVFCLR and a new overflow: the set wins.
- Pointers are TXAW+1 / RXAW+1 bits and wrap naturally; full/empty use an MSB compare.
- FLUSH in IDLE resets pointers and levels in one cycle; data content is don't-care. FLUSH in other states is ignored.
- Latency:
  - TXDATA reflects a new head the cycle after a pop or after a write to an empty FIFO.
  - RXRDATA/RXEMPTY update the cycle after a push.
  - SPISTART rises the cycle after the WAIT conditions hold.
- SYSRST mid-frame clears everything immediately. The controller has its own reset and is reset together with this block.

Test Plan:
- DWIDTH=31, write 0xA5A5_0001, CMDSTART → SPISTART the next cycle. One pop on the first TXDETECT toggle; the second toggle is ignored (TXLEVEL stays 0). RXVALID toggle with RXDATA=0x1234_5678 → RXLEVEL=1, RXRDATA=0x1234_5678, then CMDDONE pulse.
- DWIDTH=95 with only 2 TX words, CMDSTART → stays in WAIT with SPISTART=0. Write a third word → SPISTART; 3 pops; TXLEVEL=0 at CMDDONE.
- TXAW=3: write 9 words → TXFULL=1, TXLEVEL=8, TXOVF=1. OVFCLR → TXOVF=0.
- RX FIFO filled to 8 entries, then an RXVALID toggle → word dropped, RXOVF=1, RXLEVEL=8. Same-cycle RXRE and push at level 4 → level stays 4.
- Reset asserted in BUSY with TXLEVEL=5 → next cycle IDLE, TXLEVEL=0, RXEMPTY=1, SPISTART=0, no CMDDONE.
- FLUSH in BUSY → ignored. FLUSH in IDLE with levels 3/2 → both 0 one cycle later.
